reg_universal_n: RTL
====================

Name: reg_universal_n

Overview:
- Parametrised successor to the team's 1-bit edge-triggered register cell: a WIDTH-bit clocked register with synchronous reset, clock enable and eight operating modes.
- Modes are hold, load, logical shift left/right, rotate left/right, increment and decrement.
- Serves as the general-purpose accumulator/shift register beside the ALU.
- Provides a registered carry/shift-out bit and a zero flag for ALU condition logic.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- RESET_VALUE, 0, value loaded into Q on reset, truncated to WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- en  input  1  clock enable; 0 = Q and cout hold regardless of mode
- mode  input  3  operation select, decoded below
- D  input  WIDTH  parallel load data
- sin_l  input  1  serial bit entering the LSB on shift left
- sin_r  input  1  serial bit entering the MSB on shift right
- Q  output  WIDTH  register contents
- cout  output  1  registered carry/borrow/shifted-out bit
- zero  output  1  1 when Q == 0; combinational from Q

Behaviour:
- All state (Q, cout) updates only on the rising edge of clk. One-cycle latency: inputs sampled at edge k appear on Q/cout after edge k.
- Reset: rst=1 at an edge sets Q<=RESET_VALUE and cout<=0.
  - rst has priority over en and mode.
  - Reset mid-operation (e.g. during a counting run) aborts it; the next non-reset edge operates on RESET_VALUE.
  - zero follows Q, so after reset zero = (RESET_VALUE==0).
- en=0 at an edge (rst=0): Q and cout unchanged, whatever the mode, D and serial inputs.
- en=1, rst=0, by mode:
  - 000 HOLD: Q unchanged, cout unchanged.
  - 001 LOAD: Q<=D, cout<=0.
  - 010 SHL: Q<={Q[WIDTH-2:0], sin_l}, cout<=Q[WIDTH-1].
  - 011 SHR: Q<={sin_r, Q[WIDTH-1:1]}, cout<=Q[0]. Logical shift; sin_r supplies the MSB. Arithmetic shift is obtained externally by tying sin_r to Q[WIDTH-1].
  - 100 ROL: Q<={Q[WIDTH-2:0], Q[WIDTH-1]}, cout<=Q[WIDTH-1].
  - 101 ROR: Q<={Q[0], Q[WIDTH-1:1]}, cout<=Q[0].
  - 110 INC: Q<=Q+1 modulo 2^WIDTH, cout<=1 only when Q was all ones (wrap to 0), else 0.
  - 111 DEC: Q<=Q-1 modulo 2^WIDTH, cout<=1 only when Q was 0 (borrow, wrap to all ones), else 0.
- cout is sticky only across HOLD and en=0. Every other mode rewrites it each enabled cycle.
- Arithmetic is unsigned, WIDTH bits, with no saturation. Wrap-around is required behaviour and is not an error.
- No X propagation: mode is fully decoded, and all 8 codes are defined.
- zero is not registered. It must settle within the same cycle Q changes and must not glitch-latch into cout.

Test Plan:
- Reset: WIDTH=8, RESET_VALUE=8'hA5, load Q=8'h3C, then assert rst with en=0 and mode=LOAD, D=8'hFF -> after the edge Q=8'hA5, cout=0, zero=0. With RESET_VALUE=0 -> Q=0, zero=1.
- Load/hold/enable: LOAD D=8'h81 -> Q=8'h81, cout=0. Then HOLD for 3 cycles -> Q stays 8'h81. Then mode=INC with en=0 for 2 cycles -> Q stays 8'h81.
- Shifts: Q=8'h81.
  - SHL with sin_l=0 -> Q=8'h02, cout=1.
  - Then SHR with sin_r=1 -> Q=8'h81, cout=0.
  - Then SHR with sin_r=0 -> Q=8'h40, cout=1.
- Rotates: Q=8'h81.
  - ROL -> Q=8'h03, cout=1.
  - ROR twice from 8'h03 -> 8'h81 (cout=1), then 8'hC0 (cout=1).
  - Eight consecutive ROLs from 8'h5A -> Q returns to 8'h5A.
- Counter wrap: LOAD 8'hFE.
  - INC -> 8'hFF, cout=0.
  - INC -> 8'h00, cout=1, zero=1.
  - DEC -> 8'hFF, cout=1, zero=0.
  - DEC -> 8'hFE, cout=0.
- Reset mid-count: INC running from 8'h10, assert rst on the 3rd edge -> Q=RESET_VALUE. Deassert with INC held -> Q=RESET_VALUE+1 on the next edge, no lost or extra increment. Repeat the full suite at WIDTH=2 and WIDTH=32.

Source files
------------

// File: rtl/reg_universal_n.sv
// reg_universal_n: WIDTH-bit register with load, shift, rotate, inc/dec, carry-out and zero flag
module reg_universal_n #(
  parameter int          WIDTH       = 8,
  parameter logic [63:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] Q,
  output logic             cout,
  output logic             zero
);
  logic [WIDTH-1:0] nq;
  logic             nc;
  always_comb begin
    nq = Q;
    nc = cout;
    case (mode)
      3'b000: begin nq = Q;                           nc = cout;         end
      3'b001: begin nq = D;                           nc = 1'b0;         end
      3'b010: begin nq = {Q[WIDTH-2:0], sin_l};       nc = Q[WIDTH-1];   end
      3'b011: begin nq = {sin_r, Q[WIDTH-1:1]};       nc = Q[0];         end
      3'b100: begin nq = {Q[WIDTH-2:0], Q[WIDTH-1]};  nc = Q[WIDTH-1];   end
      3'b101: begin nq = {Q[0], Q[WIDTH-1:1]};        nc = Q[0];         end
      3'b110: begin nq = Q + WIDTH'(1);               nc = &Q;           end
      3'b111: begin nq = Q - WIDTH'(1);               nc = ~|Q;          end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      Q    <= RESET_VALUE[WIDTH-1:0];
      cout <= 1'b0;
    end else if (en) begin
      Q    <= nq;
      cout <= nc;
    end
  end
  assign zero = ~|Q;
endmodule
